// File: rtl/dadda_mult16_seq_ctrl.sv
// 16x16 unsigned multiplier that reuses one 8x8 Dadda/CLA core over four partial-product cycles.
// Latency is 4 cycles from accept to out_valid (1 on the zero-skip path); the product is held while out_ready is low.

module dadda_unsigned_multiplier_CLA_8 (
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] product
);
    logic [15:0] w_sum;

    // Partial-product rows summed as a flat reduction; the tree and final CLA are left to synthesis.
    always_comb begin
        w_sum = '0;
        for (int i = 0; i < 8; i++) begin
            w_sum = w_sum + ({8'd0, A & {8{B[i]}}} << i);
        end
    end

    assign product = w_sum;
endmodule

module dadda_mult16_seq_ctrl #(
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product,
    output logic        busy
);
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_step;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [31:0] r_acc;
    logic [31:0] r_product;
    logic        r_out_valid;

    logic [7:0]  w_ma;
    logic [7:0]  w_mb;
    logic [15:0] w_pp;
    logic [31:0] w_pp_shifted;
    logic [31:0] w_sum;
    logic        w_accept;
    logic        w_zero;

    assign in_ready  = (r_state == S_IDLE) && !rst;
    assign w_accept  = in_valid && in_ready;
    assign w_zero    = SKIP_ZERO && ((a == 16'd0) || (b == 16'd0));
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign product   = r_product;

    // Core inputs stay at zero outside MUL so the multiplier does not toggle while idle.
    always_comb begin
        w_ma = '0;
        w_mb = '0;
        if (r_state == S_MUL) begin
            w_ma = r_step[0] ? r_a[15:8] : r_a[7:0];
            w_mb = r_step[1] ? r_b[15:8] : r_b[7:0];
        end
    end

    dadda_unsigned_multiplier_CLA_8 u_core (
        .A       (w_ma),
        .B       (w_mb),
        .product (w_pp)
    );

    always_comb begin
        w_pp_shifted = '0;
        case (r_step)
            2'd0:    w_pp_shifted = {16'd0, w_pp};
            2'd1,
            2'd2:    w_pp_shifted = {8'd0, w_pp, 8'd0};
            default: w_pp_shifted = {w_pp, 16'd0};
        endcase
    end

    assign w_sum = r_acc + w_pp_shifted;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_zero ? S_DONE : S_MUL;
            S_MUL:   if (r_step == 2'd3) w_next = S_DONE;
            S_DONE:  if (r_out_valid && out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // In DONE with out_valid still low (zero-skip entry), out_valid rises one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_step      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_acc  <= '0;
                        r_step <= '0;
                        if (w_zero) r_product <= '0;
                    end
                end
                S_MUL: begin
                    r_acc  <= w_sum;
                    r_step <= r_step + 2'd1;
                    if (r_step == 2'd3) begin
                        r_product   <= w_sum;
                        r_out_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!r_out_valid)  r_out_valid <= 1'b1;
                    else if (out_ready) r_out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dadda_mult16_seq_ctrl.sv
// Scoreboard bench for dadda_mult16_seq_ctrl: a SKIP_ZERO=0 instance plus a SKIP_ZERO=1 instance.
module tb_dadda_mult16_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, out_ready;
    logic [15:0] a, b;
    logic        in_ready, out_valid, busy;
    logic [31:0] product;

    logic        z_in_valid, z_out_ready;
    logic [15:0] z_a, z_b;
    logic        z_in_ready, z_out_valid, z_busy;
    logic [31:0] z_product;

    int          total_cnt = 0;
    int          pass_cnt  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dadda_mult16_seq_ctrl #(.SKIP_ZERO(1'b0)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    dadda_mult16_seq_ctrl #(.SKIP_ZERO(1'b1)) dut_z (
        .clk(clk), .rst(rst), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .a(z_a), .b(z_b), .out_valid(z_out_valid), .out_ready(z_out_ready),
        .product(z_product), .busy(z_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds in_valid until the DUT takes the pair; the expected product is queued at the accept edge.
    task automatic accept(input logic [15:0] ia, input logic [15:0] ib, output bit ok);
        a = ia; b = ib; in_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                exp_q.push_back({16'd0, ia} * {16'd0, ib});
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        z_in_valid = 1'b0; z_out_ready = 1'b0; z_a = '0; z_b = '0;
        tick(); tick();
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_during got %b exp 0", in_ready); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else pass_cnt++;
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (product !== 32'd0) $display("FAIL rst_product got %h exp 0", product); else pass_cnt++;
        total_cnt++; if (z_in_ready !== 1'b1 || z_out_valid !== 1'b0) $display("FAIL rst_z got rdy %b vld %b exp 1 0", z_in_ready, z_out_valid); else pass_cnt++;
    endtask

    task automatic test_basic();
        bit ok; int cyc; bit ir_seen; logic [31:0] exp;
        out_ready = 1'b1;
        accept(16'h1234, 16'h5678, ok);
        total_cnt++; if (!ok) $display("FAIL t1_accept got timeout exp accept"); else pass_cnt++;
        cyc = 0; ir_seen = 1'b0;
        while (!out_valid && cyc < 20) begin
            if (in_ready || !busy) ir_seen = 1'b1;
            tick();
            cyc++;
        end
        total_cnt++; if (cyc != 4) $display("FAIL t1_latency got %0d exp 4", cyc); else pass_cnt++;
        total_cnt++; if (ir_seen) $display("FAIL t1_in_ready_mul got ready/idle exp busy"); else pass_cnt++;
        exp = exp_q.pop_front();
        total_cnt++; if (product !== exp) $display("FAIL t1_product got %h exp %h", product, exp); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b0) $display("FAIL t1_in_ready_done got %b exp 0", in_ready); else pass_cnt++;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL t1_out_valid_clr got %b exp 0", out_valid); else pass_cnt++;
        total_cnt++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL t1_idle got rdy %b busy %b exp 1 0", in_ready, busy); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        bit ok; int cyc; logic [31:0] exp;
        out_ready = 1'b1;
        accept(16'hFFFF, 16'hFFFF, ok);
        wait_out(cyc);
        total_cnt++; if (cyc != 4) $display("FAIL t2_max_latency got %0d exp 4", cyc); else pass_cnt++;
        exp = exp_q.pop_front();
        total_cnt++; if (product !== exp) $display("FAIL t2_max_product got %h exp %h", product, exp); else pass_cnt++;
        accept(16'h0062, 16'h0073, ok);
        total_cnt++; if (!ok) $display("FAIL t2_b2b_accept got timeout exp accept"); else pass_cnt++;
        wait_out(cyc);
        exp = exp_q.pop_front();
        total_cnt++; if (product !== exp || cyc != 4) $display("FAIL t2_b2b_product got %h/%0d exp %h/4", product, cyc, exp); else pass_cnt++;
        tick();
    endtask

    task automatic test_backpressure();
        bit ok; int cyc; logic [31:0] exp;
        out_ready = 1'b0;
        accept(16'h00AA, 16'h0063, ok);
        wait_out(cyc);
        exp = exp_q.pop_front();
        a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            total_cnt++; if (out_valid !== 1'b1 || product !== exp) $display("FAIL t3_hold%0d got %b/%h exp 1/%h", i, out_valid, product, exp); else pass_cnt++;
            total_cnt++; if (in_ready !== 1'b0) $display("FAIL t3_no_accept%0d got %b exp 0", i, in_ready); else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        tick();
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL t3_release got vld %b rdy %b exp 0 1", out_valid, in_ready); else pass_cnt++;
        accept(16'h0001, 16'h0001, ok);
        wait_out(cyc);
        exp = exp_q.pop_front();
        total_cnt++; if (product !== exp || cyc != 4) $display("FAIL t3_second got %h/%0d exp %h/4", product, cyc, exp); else pass_cnt++;
        tick();
    endtask

    task automatic test_zero();
        bit ok; int cyc; logic [31:0] exp;
        out_ready = 1'b1;
        accept(16'h0000, 16'hABCD, ok);
        wait_out(cyc);
        exp = exp_q.pop_front();
        total_cnt++; if (product !== exp || cyc != 4) $display("FAIL t4_noskip got %h/%0d exp %h/4", product, cyc, exp); else pass_cnt++;
        tick();
        z_out_ready = 1'b1;
        z_a = 16'h0003; z_b = 16'h0005; z_in_valid = 1'b1;
        tick();
        z_in_valid = 1'b0; cyc = 0;
        while (!z_out_valid && cyc < 20) begin tick(); cyc++; end
        total_cnt++; if (z_product !== 32'd15 || cyc != 4) $display("FAIL t4_skip_nonzero got %h/%0d exp 0000000f/4", z_product, cyc); else pass_cnt++;
        tick();
        z_a = 16'h0000; z_b = 16'hABCD; z_in_valid = 1'b1;
        total_cnt++; if (z_in_ready !== 1'b1) $display("FAIL t4_skip_ready got %b exp 1", z_in_ready); else pass_cnt++;
        tick();
        z_in_valid = 1'b0; cyc = 0;
        while (!z_out_valid && cyc < 20) begin tick(); cyc++; end
        total_cnt++; if (cyc != 1) $display("FAIL t4_skip_latency got %0d exp 1", cyc); else pass_cnt++;
        total_cnt++; if (z_product !== 32'd0) $display("FAIL t4_skip_product got %h exp 0", z_product); else pass_cnt++;
        tick();
        total_cnt++; if (z_out_valid !== 1'b0 || z_busy !== 1'b0) $display("FAIL t4_skip_done got vld %b busy %b exp 0 0", z_out_valid, z_busy); else pass_cnt++;
    endtask

    task automatic test_reset_mul();
        bit ok; int cyc; bit seen; logic [31:0] exp;
        out_ready = 1'b1;
        accept(16'h1234, 16'h5678, ok);
        tick(); tick();
        rst = 1'b1;
        tick();
        void'(exp_q.pop_back());
        total_cnt++; if (out_valid !== 1'b0 || busy !== 1'b0 || product !== 32'd0) $display("FAIL t5_rst_state got vld %b busy %b prod %h exp 0 0 0", out_valid, busy, product); else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++; if (in_ready !== 1'b1) $display("FAIL t5_in_ready got %b exp 1", in_ready); else pass_cnt++;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        total_cnt++; if (seen) $display("FAIL t5_no_output got out_valid exp none"); else pass_cnt++;
        accept(16'h0002, 16'h0003, ok);
        wait_out(cyc);
        exp = exp_q.pop_front();
        total_cnt++; if (product !== exp || cyc != 4) $display("FAIL t5_after got %h/%0d exp %h/4", product, cyc, exp); else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_done();
        bit ok; int cyc; logic [31:0] exp;
        out_ready = 1'b0;
        accept(16'h0101, 16'h0202, ok);
        wait_out(cyc);
        exp = exp_q.pop_front();
        total_cnt++; if (product !== exp || out_valid !== 1'b1) $display("FAIL t6_pre got %h/%b exp %h/1", product, out_valid, exp); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL t6_post got vld %b rdy %b busy %b exp 0 1 0", out_valid, in_ready, busy); else pass_cnt++;
        out_ready = 1'b1;
        tick();
        total_cnt++; if (out_valid !== 1'b0) $display("FAIL t6_stays_idle got %b exp 0", out_valid); else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_zero();
        test_reset_mul();
        test_reset_done();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
